// File: rtl/payload_crc_checker.sv
// payload_crc_checker
//   Counts the payload bytes and the 4-byte trailing FCS of a frame, after the
//   header parser hands over. At the last byte it checks the payload length
//   against [PAYLOAD_MIN, PAYLOAD_MAX]. It can also check the Ethernet CRC-32
//   residue on the fly. All results are registered and are held until enable
//   drops.
//
// Ports
//   clock              rising-edge clock
//   reset              asynchronous, active-high clear of all state/outputs
//   enable             field parsing in progress; low aborts to IDLE
//   byte_valid         data_in carries a byte this cycle
//   data_in[7:0]       payload/FCS byte (FCS LSB-byte first)
//   last               with byte_valid, marks the final FCS byte
//   byte_count         bytes accepted this frame (payload+FCS), saturating
//   done               one-cycle pulse: frame result valid
//   packet_size_valid  payload length within bounds
//   crc_ok             FCS residue correct (forced 1 when CHECK_CRC=0)
//   oversize           count passed PAYLOAD_MAX+4 without last
module payload_crc_checker #(
  parameter int PAYLOAD_MIN = 46,
  parameter int PAYLOAD_MAX = 1500,
  parameter int COUNT_W     = 11,
  parameter int CHECK_CRC   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               byte_valid,
  input  logic [7:0]         data_in,
  input  logic               last,
  output logic [COUNT_W-1:0] byte_count,
  output logic               done,
  output logic               packet_size_valid,
  output logic               crc_ok,
  output logic               oversize
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE, OVERSIZE} state_t;

  localparam int CNT_MAX = (2 ** COUNT_W) - 1;
  // The oversize length is clamped to the saturation value, so the
  // comparison still works if PAYLOAD_MAX+5 does not fit in the counter.
  localparam int OV_INT  = (PAYLOAD_MAX + 5 > CNT_MAX) ? CNT_MAX : PAYLOAD_MAX + 5;
  localparam logic [COUNT_W-1:0] LEN_LO = COUNT_W'(PAYLOAD_MIN + 4);
  localparam logic [COUNT_W-1:0] LEN_HI = COUNT_W'(PAYLOAD_MAX + 4);
  localparam logic [COUNT_W-1:0] OV_LEN = COUNT_W'(OV_INT);

  state_t             state, state_d;
  logic               accept;
  logic [COUNT_W-1:0] count_inc;
  logic [COUNT_W-1:0] count_d;
  logic               done_d, psv_d, crc_ok_d, ov_d;
  logic               len_ok;
  logic               crc_match;

  assign accept    = enable && byte_valid && ((state == IDLE) || (state == COUNT));
  assign count_inc = (byte_count == '1) ? byte_count : byte_count + COUNT_W'(1);
  // L >= PAYLOAD_MIN+4 also rules out L < 4, where the payload length is undefined.
  assign len_ok    = (count_inc >= LEN_LO) && (count_inc <= LEN_HI);

  generate
    if (CHECK_CRC != 0) begin : g_crc
      localparam logic [31:0] POLY    = 32'hEDB88320;
      localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
      logic [31:0] crc_q, crc_next;

      always_comb begin
        crc_next = crc_q ^ {24'h000000, data_in};
        for (int unsigned i = 0; i < 8; i++) begin
          crc_next = crc_next[0] ? ((crc_next >> 1) ^ POLY) : (crc_next >> 1);
        end
      end

      // crc_q is preset whenever the next state is IDLE, so it is always
      // 0xFFFFFFFF when a new frame starts.
      always_ff @(posedge clock or posedge reset) begin
        if (reset)                crc_q <= '1;
        else if (state_d == IDLE) crc_q <= '1;
        else if (accept)          crc_q <= crc_next;
      end

      assign crc_match = (crc_next == RESIDUE);
    end else begin : g_nocrc
      assign crc_match = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d  = state;
    count_d  = byte_count;
    done_d   = 1'b0;
    psv_d    = packet_size_valid;
    crc_ok_d = crc_ok;
    ov_d     = oversize;
    if (!enable) begin
      state_d  = IDLE;
      count_d  = '0;
      psv_d    = 1'b0;
      crc_ok_d = 1'b0;
      ov_d     = 1'b0;
    end else if (accept) begin
      count_d = count_inc;
      if (last) begin
        state_d  = DONE;
        done_d   = 1'b1;
        psv_d    = len_ok;
        crc_ok_d = crc_match;
      end else if (count_inc == OV_LEN) begin
        state_d  = OVERSIZE;
        ov_d     = 1'b1;
        psv_d    = 1'b0;
        crc_ok_d = 1'b0;
      end else begin
        state_d  = COUNT;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      byte_count        <= '0;
      done              <= 1'b0;
      packet_size_valid <= 1'b0;
      crc_ok            <= 1'b0;
      oversize          <= 1'b0;
    end else begin
      state             <= state_d;
      byte_count        <= count_d;
      done              <= done_d;
      packet_size_valid <= psv_d;
      crc_ok            <= crc_ok_d;
      oversize          <= ov_d;
    end
  end

endmodule

// File: tb/tb_payload_crc_checker.sv
// Testbench for payload_crc_checker. Two instances share the stimulus:
// dut_a uses PAYLOAD_MIN=9 and dut_b uses the default parameters.
module tb_payload_crc_checker;

  logic        clock = 1'b0;
  logic        reset, enable, byte_valid, last;
  logic [7:0]  data_in;
  logic [10:0] bc_a, bc_b;
  logic        done_a, psv_a, crc_a, ov_a;
  logic        done_b, psv_b, crc_b, ov_b;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int d0;

  logic [7:0] frm [0:1599];

  payload_crc_checker #(.PAYLOAD_MIN(9)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .byte_valid(byte_valid),
    .data_in(data_in), .last(last), .byte_count(bc_a), .done(done_a),
    .packet_size_valid(psv_a), .crc_ok(crc_a), .oversize(ov_a)
  );

  payload_crc_checker dut_b (
    .clock(clock), .reset(reset), .enable(enable), .byte_valid(byte_valid),
    .data_in(data_in), .last(last), .byte_count(bc_b), .done(done_b),
    .packet_size_valid(psv_b), .crc_ok(crc_b), .oversize(ov_b)
  );

  always #5 clock = ~clock;

  // Count done pulses. Each pulse is seen once, on the edge that ends its cycle.
  always @(posedge clock) begin
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference bit-serial reflected CRC-32 over frm[0..n-1]. Returns the FCS value.
  function automatic logic [31:0] crc_ref(input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++)
        if (c[0] ^ frm[i][j]) c = (c >> 1) ^ 32'hEDB88320;
        else                  c = c >> 1;
    return ~c;
  endfunction

  task automatic build_frame(input int plen, input int seed);
    logic [31:0] fcs;
    for (int i = 0; i < plen; i++) frm[i] = 8'((i * 13 + seed) & 255);
    fcs = crc_ref(plen);
    frm[plen]   = fcs[7:0];
    frm[plen+1] = fcs[15:8];
    frm[plen+2] = fcs[23:16];
    frm[plen+3] = fcs[31:24];
  endtask

  task automatic send_frame(input int n, input bit gaps, input bit with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (gaps && (i % 3 == 1)) begin
        byte_valid = 1'b0;
        last       = 1'b0;
        @(negedge clock);
      end
      byte_valid = 1'b1;
      data_in    = frm[i];
      last       = with_last && (i == n - 1);
    end
    @(negedge clock);
    byte_valid = 1'b0;
    last       = 1'b0;
  endtask

  task automatic restart();
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
  endtask

  // Called on the first negedge after the edge that accepted the last byte.
  task automatic check_result(input string tag, input int cnt, input bit pa, input bit pb, input bit cr);
    check({tag, ".done"},  32'(done_a), 32'd1);
    check({tag, ".count"}, 32'(bc_a),   32'(cnt));
    check({tag, ".psv_a"}, 32'(psv_a),  32'(pa));
    check({tag, ".crc_a"}, 32'(crc_a),  32'(cr));
    check({tag, ".ov"},    32'(ov_a),   32'd0);
    check({tag, ".psv_b"}, 32'(psv_b),  32'(pb));
    check({tag, ".crc_b"}, 32'(crc_b),  32'(cr));
    @(negedge clock);
    check({tag, ".done_low"}, 32'(done_a), 32'd0);
    check({tag, ".psv_hold"}, 32'(psv_a),  32'(pa));
    check({tag, ".crc_hold"}, 32'(crc_a),  32'(cr));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; byte_valid = 1'b0; last = 1'b0; data_in = 8'h00;
    #1;
    check("rst.count", 32'(bc_a),  32'd0);
    check("rst.done",  32'(done_a), 32'd0);
    check("rst.psv",   32'(psv_a), 32'd0);
    check("rst.crc",   32'(crc_a), 32'd0);
    check("rst.ov",    32'(ov_a),  32'd0);
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b1;

    // "123456789" with FCS 0xCBF43926 sent LSB-first
    frm[0] = 8'h31; frm[1] = 8'h32; frm[2] = 8'h33; frm[3] = 8'h34;
    frm[4] = 8'h35; frm[5] = 8'h36; frm[6] = 8'h37; frm[7] = 8'h38;
    frm[8] = 8'h39; frm[9] = 8'h26; frm[10] = 8'h39; frm[11] = 8'hF4;
    frm[12] = 8'hCB;
    send_frame(13, 1'b0, 1'b1);
    check_result("t1", 13, 1'b1, 1'b0, 1'b1);
    check("t1.done_cnt", 32'(done_cnt_a), 32'd1);

    restart();
    send_frame(13, 1'b1, 1'b1);
    check_result("t2gap", 13, 1'b1, 1'b0, 1'b1);

    restart();
    frm[4] = 8'h36;
    send_frame(13, 1'b0, 1'b1);
    check_result("t3bad", 13, 1'b1, 1'b0, 1'b0);
    frm[4] = 8'h35;

    restart();
    build_frame(45, 1);
    send_frame(49, 1'b0, 1'b1);
    check_result("t4short", 49, 1'b1, 1'b0, 1'b1);

    restart();
    build_frame(1500, 2);
    send_frame(1504, 1'b0, 1'b1);
    check_result("t5max", 1504, 1'b1, 1'b1, 1'b1);

    // Oversize: 1505 bytes without last
    restart();
    send_frame(1504, 1'b0, 1'b0);
    check("t6.ov_before", 32'(ov_b), 32'd0);
    check("t6.cnt_before", 32'(bc_b), 32'd1504);
    send_frame(1, 1'b0, 1'b0);
    check("t6.ov", 32'(ov_b), 32'd1);
    check("t6.cnt", 32'(bc_b), 32'd1505);
    check("t6.psv", 32'(psv_b), 32'd0);
    check("t6.crc", 32'(crc_b), 32'd0);
    d0 = done_cnt_b;
    send_frame(1, 1'b0, 1'b1);
    @(negedge clock);
    check("t6.no_done", 32'(done_cnt_b), 32'(d0));
    check("t6.cnt_hold", 32'(bc_b), 32'd1505);
    check("t6.ov_hold", 32'(ov_b), 32'd1);
    enable = 1'b0;
    @(negedge clock);
    check("t6.clr_cnt", 32'(bc_b), 32'd0);
    check("t6.clr_ov", 32'(ov_b), 32'd0);
    check("t6.clr_psv", 32'(psv_b), 32'd0);
    check("t6.clr_crc", 32'(crc_b), 32'd0);
    enable = 1'b1;

    // Abort after 20 bytes. A byte on the same edge as the enable drop is lost.
    build_frame(60, 4);
    send_frame(20, 1'b0, 1'b0);
    check("t7.cnt20", 32'(bc_a), 32'd20);
    d0 = done_cnt_a;
    @(negedge clock);
    enable = 1'b0; byte_valid = 1'b1; data_in = frm[20]; last = 1'b0;
    @(negedge clock);
    byte_valid = 1'b0;
    check("t7.abort_cnt", 32'(bc_a), 32'd0);
    enable = 1'b1;
    send_frame(64, 1'b0, 1'b1);
    check_result("t7", 64, 1'b1, 1'b1, 1'b1);
    check("t7.done_cnt", 32'(done_cnt_a), 32'(d0 + 1));

    // Asynchronous reset mid-frame
    restart();
    build_frame(60, 5);
    send_frame(30, 1'b0, 1'b0);
    check("t8.cnt30", 32'(bc_a), 32'd30);
    #2;
    reset = 1'b1;
    #1;
    check("t8.rst_cnt", 32'(bc_a), 32'd0);
    check("t8.rst_psv", 32'(psv_a), 32'd0);
    check("t8.rst_ov", 32'(ov_a), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    send_frame(64, 1'b0, 1'b1);
    check_result("t8", 64, 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/payload_crc_checker.md
# payload_crc_checker

Parametrised successor to the fixed 50-byte payload/CRC counter. Consumes the byte stream after the header parser hands over, and counts payload plus a 4-byte trailing FCS with a valid-qualified handshake. It checks the payload length against configurable bounds and, optionally, computes and validates Ethernet CRC-32 on the fly. Results are presented as registered, held status flags to the packet-level controller.

## Interface
- PAYLOAD_MIN, 46, minimum legal payload length in bytes (FCS excluded)
- PAYLOAD_MAX, 1500, maximum legal payload length in bytes (FCS excluded)
- COUNT_W, 11, byte counter width; must satisfy 2^COUNT_W > PAYLOAD_MAX+4
- CHECK_CRC, 1, 1 = validate CRC-32; 0 = count only, crc_ok forced 1 at done
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- enable  input  1  active-high; field parsing in progress; low = abort/idle
- byte_valid  input  1  data_in carries a byte this cycle
- data_in  input  8  payload/FCS byte, FCS sent LSB-byte first
- last  input  1  qualifies byte_valid; marks final FCS byte of frame
- byte_count  output  COUNT_W  bytes accepted this frame (payload+FCS), saturating
- done  output  1  one-cycle pulse: frame result now valid
- packet_size_valid  output  1  payload length within [PAYLOAD_MIN, PAYLOAD_MAX]
- crc_ok  output  1  FCS residue correct
- oversize  output  1  byte count exceeded PAYLOAD_MAX+4 without last

## Operation
- Byte accepted on a rising edge when enable=1 and byte_valid=1 in state IDLE or COUNT; gaps (byte_valid=0) stall without effect.
- States: IDLE, COUNT, DONE, OVERSIZE.
- IDLE -> COUNT on the first accepted byte; accepted byte with last=1 in IDLE/COUNT -> DONE.
- COUNT -> OVERSIZE when an accepted byte without last makes byte_count = PAYLOAD_MAX+5.
- DONE and OVERSIZE ignore further bytes and hold results while enable=1.
- enable=0 in any state -> IDLE next edge; byte_count, packet_size_valid, crc_ok and oversize are cleared; no done pulse for an aborted frame.
- Length rule at last byte: L = byte_count after increment; P = L-4 (L<4 gives P invalid, packet_size_valid=0); packet_size_valid = (PAYLOAD_MIN ≤ P ≤ PAYLOAD_MAX).
- CRC: reflected CRC-32, polynomial 0xEDB88320, register preset 0xFFFFFFFF at every IDLE, updated one byte per accepted byte over payload and FCS. crc_ok = (register == 0xDEBB20E3) after the last byte. CHECK_CRC=0: CRC logic absent and crc_ok=1 at DONE.
- OVERSIZE: oversize=1, packet_size_valid=0, crc_ok=0; a later last byte produces no done pulse. The controller recovers by dropping enable.
- byte_count saturates at 2^COUNT_W-1 and never wraps.

## Timing
- Reset values: byte_count=0, done=0, packet_size_valid=0, crc_ok=0, oversize=0, state IDLE, CRC register 0xFFFFFFFF.
- All outputs registered. byte_count reflects an accepted byte one cycle after its edge.
- done, packet_size_valid and crc_ok assert in the cycle after the edge that accepted last. done is high for exactly one cycle, and the flags hold until enable=0 or reset.
- oversize asserts in the cycle after the edge accepting byte PAYLOAD_MAX+5.
- Throughput: one byte per clock, no back-pressure.
- enable falling and byte_valid on the same edge: byte is not accepted and the abort wins.
- reset mid-frame: immediate clear. Parsing resumes from IDLE on the first edge after reset release with enable=1.

## Test plan
- PAYLOAD_MIN=9: send ASCII "123456789" then FCS 26 39 F4 CB (last on 0xCB), one byte/cycle -> byte_count=13, done pulse 1 cycle, packet_size_valid=1, crc_ok=1, oversize=0.
- Same frame with byte 5 flipped to 0x36, or with random byte_valid gaps -> corrupted frame gives crc_ok=0, packet_size_valid=1; gapped clean frame gives identical results to the gap-free frame.
- Defaults, 49-byte frame (45 payload + valid FCS) -> packet_size_valid=0, crc_ok=1. 1504-byte frame -> packet_size_valid=1.
- Defaults, 1505 bytes without last -> oversize=1 one cycle after byte 1505, byte_count=1505. A subsequent last byte gives no done pulse. enable=0 clears all outputs.
- Drop enable after byte 20 of a 64-byte frame, then re-raise and send a clean 64-byte frame -> no done for the first frame, correct results for the second.
- Assert reset after byte 30 -> all outputs 0 asynchronously. The next clean frame passes with crc_ok=1.
